// File: rtl/addsub_pkg.sv
// Shared opcodes and configuration check for the pipelined add/subtract unit.
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic bit cfg_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: {co, s} = a + b + ci.
// Purely combinational, no flow control.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// Ripple-carry adder over one CHUNK-bit slice, built from full_adder cells.
// Purely combinational, no flow control.
module rca_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum[i]),
         .co (c[i+1])
      );
   end

   assign cout = c[CHUNK];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one ripple chunk per stage, STAGES-cycle latency, one beat/cycle.
// Valid/ready both sides; a stalled output holds out_* and bubbles collapse upstream.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int CHUNK = WIDTH / STAGES;

   if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
      $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   logic [WIDTH-1:0]  a_x, b_x;
   logic              c_x;
   logic [STAGES-1:0] v_d, v_q, v_src, adv, ld;
   logic              full_run;

   // Subtraction is a + ~b + ~borrow, so stage 0 sees a plain add either way
   always_comb begin
      a_x = in_a;
      b_x = (in_sub == OP_ADD) ? in_b : ~in_b;
      c_x = (in_sub == OP_SUB) ? ~in_cin : in_cin;
   end

   // A stage may move when any stage at or after it is empty, or the output is popped
   always_comb begin
      full_run = 1'b1;
      adv      = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         full_run = full_run & v_q[k];
         adv[k]   = out_ready | ~full_run;
      end
   end

   always_comb begin
      v_src[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         v_src[k] = v_q[k-1];
      end
      ld  = adv & v_src;
      v_d = (adv & v_src) | (~adv & v_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) v_q <= '0;
      else        v_q <= v_d;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * CHUNK;
      localparam int HI = LO + CHUNK;

      logic [CHUNK-1:0] op_a, op_b, chunk_sum;
      logic             op_c, chunk_cout;
      logic [HI-1:0]    sum_d, sum_q;
      logic             carry_d, carry_q;

      rca_chunk #(.CHUNK(CHUNK)) u_rca (
         .a    (op_a),
         .b    (op_b),
         .cin  (op_c),
         .sum  (chunk_sum),
         .cout (chunk_cout)
      );

      if (k == 0) begin : g_src
         always_comb begin
            op_a    = a_x[CHUNK-1:0];
            op_b    = b_x[CHUNK-1:0];
            op_c    = c_x;
            sum_d   = chunk_sum;
            carry_d = chunk_cout;
         end
      end else begin : g_src
         always_comb begin
            op_a    = g_st[k-1].g_ops.a_q[HI-1:LO];
            op_b    = g_st[k-1].g_ops.b_q[HI-1:LO];
            op_c    = g_st[k-1].carry_q;
            sum_d   = {chunk_sum, g_st[k-1].sum_q};
            carry_d = chunk_cout;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
         end else if (ld[k]) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
         end
      end

      // Operand chunks not yet consumed ride along, shrinking by one chunk per stage
      if (k < STAGES - 1) begin : g_ops
         logic [WIDTH-1:HI] a_d, a_q, b_d, b_q;

         if (k == 0) begin : g_in
            always_comb begin
               a_d = a_x[WIDTH-1:HI];
               b_d = b_x[WIDTH-1:HI];
            end
         end else begin : g_in
            always_comb begin
               a_d = g_st[k-1].g_ops.a_q[WIDTH-1:HI];
               b_d = g_st[k-1].g_ops.b_q[WIDTH-1:HI];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (ld[k]) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end

      if (k == STAGES - 1) begin : g_flags
         logic ovf_d, ovf_q, zero_d, zero_q;

         always_comb begin
            ovf_d  = (op_a[CHUNK-1] ~^ op_b[CHUNK-1]) & (chunk_sum[CHUNK-1] ^ op_a[CHUNK-1]);
            zero_d = (sum_d == '0);
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (ld[k]) begin
               ovf_q  <= ovf_d;
               zero_q <= zero_d;
            end
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v_q[STAGES-1];
   assign out_sum   = g_st[STAGES-1].sum_q;
   assign out_cout  = g_st[STAGES-1].carry_q;
   assign out_ovf   = g_st[STAGES-1].g_flags.ovf_q;
   assign out_zero  = g_st[STAGES-1].g_flags.zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three configurations (8/2, 32/4, 16/1) share one stimulus bus,
// results are checked against an arithmetic reference queue.
module tb_pipelined_addsub;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_cin, in_sub, out_ready;
   logic [31:0] in_a, in_b;
   int          sel;

   logic        iv8, r8, v8, c8, o8, z8;
   logic [7:0]  s8;
   logic        iv32, r32, v32, c32, o32, z32;
   logic [31:0] s32;
   logic        iv16, r16, v16, c16, o16, z16;
   logic [15:0] s16;

   logic        obs_rdy, obs_vld, obs_cout, obs_ovf, obs_zero;
   logic [31:0] obs_sum;

   always #5 clk = ~clk;

   assign iv8  = in_valid && (sel == 0);
   assign iv32 = in_valid && (sel == 1);
   assign iv16 = in_valid && (sel == 2);

   pipelined_addsub #(.WIDTH(8), .STAGES(2)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(r8),
      .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(v8), .out_ready(out_ready), .out_sum(s8), .out_cout(c8),
      .out_ovf(o8), .out_zero(z8));

   pipelined_addsub #(.WIDTH(32), .STAGES(4)) u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(r32),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(v32), .out_ready(out_ready), .out_sum(s32), .out_cout(c32),
      .out_ovf(o32), .out_zero(z32));

   pipelined_addsub #(.WIDTH(16), .STAGES(1)) u16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(r16),
      .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(v16), .out_ready(out_ready), .out_sum(s16), .out_cout(c16),
      .out_ovf(o16), .out_zero(z16));

   always_comb begin
      case (sel)
         1: begin
            obs_rdy = r32; obs_vld = v32; obs_sum = s32;
            obs_cout = c32; obs_ovf = o32; obs_zero = z32;
         end
         2: begin
            obs_rdy = r16; obs_vld = v16; obs_sum = {16'h0, s16};
            obs_cout = c16; obs_ovf = o16; obs_zero = z16;
         end
         default: begin
            obs_rdy = r8; obs_vld = v8; obs_sum = {24'h0, s8};
            obs_cout = c8; obs_ovf = o8; obs_zero = z8;
         end
      endcase
   end

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc_no = 0;
   int   n_push = 0;
   int   n_pop = 0;
   int   cw = 8;
   int   cs = 2;
   bit   lat_chk = 1'b0;
   bit   prev_stall = 1'b0;

   task automatic check(input string tag, input longint obs, input longint want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   // Reference: exact integer arithmetic, then reduce to w bits
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input bit cin, input bit sub, input int w);
      exp_t   e;
      longint m, half, ua, ub, r, sa, sb, sr;
      m    = (longint'(1) <<< w) - 1;
      half = longint'(1) <<< (w - 1);
      ua   = {32'h0, a} & m;
      ub   = {32'h0, b} & m;
      r    = sub ? ua - ub - longint'(cin) : ua + ub + longint'(cin);
      sa   = (ua >= half) ? ua - 2 * half : ua;
      sb   = (ub >= half) ? ub - 2 * half : ub;
      sr   = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
      e.sum  = 32'(r & m);
      e.cout = sub ? (r >= 0) : (r > m);
      e.ovf  = (sr < -half) || (sr > half - 1);
      e.zero = ((r & m) == 0);
      e.acc  = 0;
      return e;
   endfunction

   task automatic cyc(input bit iv, input bit ordy, input logic [31:0] a,
                      input logic [31:0] b, input bit cin, input bit sub);
      exp_t e;
      @(negedge clk);
      in_a = a; in_b = b; in_cin = cin; in_sub = sub;
      in_valid = iv; out_ready = ordy;
      #1;
      if (prev_stall) check("held_valid", obs_vld, 1);
      if (obs_vld) begin
         if (q.size() == 0) begin
            check("spurious_out", obs_vld, 0);
         end else begin
            e = q[0];
            check("sum", obs_sum, e.sum);
            check("cout", obs_cout, e.cout);
            check("ovf", obs_ovf, e.ovf);
            check("zero", obs_zero, e.zero);
            if (ordy) begin
               if (lat_chk) check("latency", cyc_no - e.acc, cs);
               void'(q.pop_front());
               n_pop++;
            end
         end
      end
      prev_stall = obs_vld && !ordy;
      if (iv && obs_rdy) begin
         e = model(a, b, cin, sub, cw);
         e.acc = cyc_no;
         q.push_back(e);
         n_push++;
      end
      cyc_no++;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 200) begin
         cyc(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
         n++;
      end
      check("drain_left", q.size(), 0);
   endtask

   task automatic rand_run(input int beats);
      int n0 = n_push;
      int guard = 0;
      while ((n_push - n0) < beats && guard < 40000) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom(), $urandom(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         guard++;
      end
      check("rand_beats", n_push - n0, beats);
      drain();
   endtask

   initial begin
      int p0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; sel = 0;
      repeat (2) @(negedge clk);

      // Reset state of every configuration
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("rst_valid", obs_vld, 0);
         check("rst_ready", obs_rdy, 1);
         check("rst_sum", obs_sum, 0);
         check("rst_cout", obs_cout, 0);
         check("rst_ovf", obs_ovf, 0);
         check("rst_zero", obs_zero, 0);
      end
      sel = 0; cw = 8; cs = 2;
      @(negedge clk);
      rst_n = 1'b1;

      // Directed arithmetic corners with latency checking
      lat_chk = 1'b1;
      cyc(1, 1, 32'hFF, 32'h01, 0, 0);
      cyc(1, 1, 32'h80, 32'h01, 0, 1);
      cyc(1, 1, 32'h00, 32'h01, 0, 1);
      cyc(1, 1, 32'h7F, 32'h01, 0, 0);
      cyc(1, 1, 32'hFE, 32'h01, 1, 0);
      cyc(1, 1, 32'h05, 32'h05, 0, 1);
      drain();

      // 20 back-to-back beats
      p0 = n_pop;
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("t4_in_ready", obs_rdy, 1);
      end
      drain();
      check("t4_count", n_pop - p0, 20);
      lat_chk = 1'b0;

      // Output stalled for 6 cycles, then released with input still streaming
      for (int i = 0; i < 6; i++) begin
         cyc(1, 0, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("t5_in_ready_stall", obs_rdy, (i < cs) ? 1 : 0);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("t5_in_ready_swap", obs_rdy, 1);
      end
      drain();

      // Reset in the middle of a stream
      for (int i = 0; i < 3; i++) cyc(1, 1, $urandom(), $urandom(), 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", obs_vld, 0);
      check("t6_rst_ready", obs_rdy, 1);
      q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc(0, 1, 32'h0, 32'h0, 0, 0);
         check("t6_idle_valid", obs_vld, 0);
      end
      cyc(1, 1, 32'h12, 32'h34, 1, 0);
      drain();

      // Random streams with random backpressure
      sel = 1; cw = 32; cs = 4;
      rand_run(10000);
      sel = 2; cw = 16; cs = 1;
      rand_run(10000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
